alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single-cycle integer ALU between two requesters: req0 = EX stage, req1 = branch-target/compare helper.
- Arbitration is round-robin. Requesters can lock the ALU for atomic multi-op sequences.
- The arbiter drives the ALU operand and op buses combinationally and registers the result, Z and N into a one-entry response buffer with a valid/ready handshake.
- Sits between the pipeline control and the ALU. The ALU itself is not modified.

Parameters:
WIDTH, 32, operand/result width
OPW, 3, ALU op-code width (000 add B+A, 110 negate B, 101 B-A, 111 pass A, others yield 0)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  operand A
req0_b  input  WIDTH  operand B
req0_op  input  OPW  ALU op-code
req0_lock  input  1  keep grant after this op
req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_lock  same as req0 for requester 1
alu_a  output  WIDTH  to ALU operand A
alu_b  output  WIDTH  to ALU operand B
alu_op  output  OPW  to ALU op-code
alu_out  input  WIDTH  ALU result
alu_z  input  1  ALU zero flag
alu_n  input  1  ALU negative flag
rsp_valid  output  1  response buffer full
rsp_id  output  1  requester that owns the response
rsp_data  output  WIDTH  registered result
rsp_z  output  1  registered Z
rsp_n  output  1  registered N
rsp_ready  input  1  consumer takes the response
busy  output  1  state != IDLE or rsp_valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0 (req0 preferred), rsp_valid=0, rsp_id=0, rsp_data=0, rsp_z=0, rsp_n=0. All outputs settle immediately without a clock edge.
- Reset mid-operation: any buffered response is discarded and any lock is dropped.
- can_accept = !rsp_valid || rsp_ready. A same-cycle drain and refill is allowed, giving full throughput of 1 op/cycle.
- Grant is combinational and registered nowhere. At most one reqN_ready is high per cycle. reqN_ready = can_accept && grantN && reqN_valid.
- States:
  - IDLE: if only one requester is valid, that requester is granted. If both are valid, the requester selected by rr_ptr is granted.
  - LOCK0: only req0 can be granted. req1_ready=0 regardless of req1_valid.
  - LOCK1: mirror of LOCK0 for req1.
- Transitions, on an accepted op from requester k:
  - IDLE -> LOCKk if reqk_lock=1.
  - LOCKk -> IDLE if reqk_lock=0.
  - Otherwise the state holds. A lock persists across idle cycles of the owner.
- rr_ptr update: on any accepted op in IDLE with lock=0, rr_ptr = ~k. On the op that releases LOCKk, rr_ptr = ~k. No requester waits more than one competing op plus one locked sequence.
- ALU drive: when a grant is active, alu_a/alu_b/alu_op = granted operands. Otherwise they are driven to 0/0/000. The ALU is not re-registered.
- Latency: op accepted in cycle T -> rsp_valid=1 with rsp_data=alu_out, rsp_z=alu_z, rsp_n=alu_n and rsp_id=k in cycle T+1.
- Response hold: the response is held stable while rsp_valid && !rsp_ready.
- Response drop: rsp_valid falls after a handshake when no new op is accepted in the same cycle.
- Op-codes are forwarded unfiltered. Undefined codes produce rsp_data=0, rsp_z=1, rsp_n=0, as returned by the ALU.
- Backpressure (rsp_valid && !rsp_ready): no grant, both ready outputs stay 0, and state and rr_ptr hold.
- Width rules: the arbiter performs no arithmetic on operands. rsp_data is exactly WIDTH bits, wrap-around is the ALU's.

Test Plan:
- Reset with rsp_valid=1 mid-cycle (rst_n low asynchronously) -> rsp_valid, rsp_data, busy go to 0 before the next clk edge. The first op after release is granted to req0 when both are valid.
- req0 only: a=5, b=7, op=000, rsp_ready=1 -> req0_ready=1 at T. At T+1: rsp_data=12, rsp_z=0, rsp_n=0, rsp_id=0. Back-to-back ops every cycle.
- Both valid continuously, no lock, req0 a=3 b=3 op=101, req1 a=0 b=1 op=110 -> grants alternate 0,1,0,1. req0 responses are 0 with z=1. req1 responses are 0xFFFFFFFF with n=1.
- req1 lock=1 on two ops, then lock=0 on the third, with req0 valid throughout -> req0_ready=0 for all three req1 ops. req0 is granted on the next cycle.
- rsp_ready=0 for 3 cycles after a response, both requesters valid -> response held stable, both ready=0, rr_ptr unchanged. On rsp_ready=1 the next op is accepted in the same cycle.
- op=011 from req0, a=9 b=4 -> rsp_data=0, rsp_z=1, rsp_n=0, no error or stall.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one single-cycle ALU between two requesters,
// with per-requester locking and a one-entry registered response buffer.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [OPW-1:0]   req0_op_i,
  input  logic             req0_lock_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [OPW-1:0]   req1_op_i,
  input  logic             req1_lock_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [OPW-1:0]   alu_op_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_z_i,
  input  logic             alu_n_i,
  output logic             rsp_valid_o,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_z_o,
  output logic             rsp_n_o,
  input  logic             rsp_ready_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_z_q, rsp_z_d;
  logic             rsp_n_q, rsp_n_d;

  logic can_accept_s;
  logic gnt0_s, gnt1_s;
  logic acc0_s, acc1_s, acc_s;
  logic acc_lock_s;

  assign can_accept_s = !rsp_valid_q || rsp_ready_i;

  // Grant selection; rr_q only breaks ties in IDLE.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid_i && req1_valid_i) begin
          gnt0_s = ~rr_q;
          gnt1_s = rr_q;
        end else begin
          gnt0_s = req0_valid_i;
          gnt1_s = req1_valid_i;
        end
      end
      LOCK0:   gnt0_s = req0_valid_i;
      LOCK1:   gnt1_s = req1_valid_i;
      default: gnt0_s = 1'b0;
    endcase
  end

  assign acc0_s       = can_accept_s && gnt0_s;
  assign acc1_s       = can_accept_s && gnt1_s;
  assign acc_s        = acc0_s || acc1_s;
  assign acc_lock_s   = acc1_s ? req1_lock_i : req0_lock_i;
  assign req0_ready_o = acc0_s;
  assign req1_ready_o = acc1_s;

  // ALU operand mux; buses are zeroed when nothing is granted.
  always_comb begin
    if (acc0_s) begin
      alu_a_o  = req0_a_i;
      alu_b_o  = req0_b_i;
      alu_op_o = req0_op_i;
    end else if (acc1_s) begin
      alu_a_o  = req1_a_i;
      alu_b_o  = req1_b_i;
      alu_op_o = req1_op_i;
    end else begin
      alu_a_o  = {WIDTH{1'b0}};
      alu_b_o  = {WIDTH{1'b0}};
      alu_op_o = {OPW{1'b0}};
    end
  end

  // Lock state and round-robin pointer next-state.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (acc_s) begin
      case (state_q)
        IDLE: begin
          if (acc_lock_s) begin
            state_d = acc1_s ? LOCK1 : LOCK0;
          end else begin
            rr_d = ~acc1_s;
          end
        end
        LOCK0, LOCK1: begin
          if (!acc_lock_s) begin
            state_d = IDLE;
            rr_d    = ~acc1_s;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Response buffer next-state: refill on accept, drain on handshake.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_z_d     = rsp_z_q;
    rsp_n_d     = rsp_n_q;
    if (acc_s) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = acc1_s;
      rsp_data_d  = alu_out_i;
      rsp_z_d     = alu_z_i;
      rsp_n_d     = alu_n_i;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= {WIDTH{1'b0}};
      rsp_z_q     <= 1'b0;
      rsp_n_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_z_q     <= rsp_z_d;
      rsp_n_q     <= rsp_n_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_z_o     = rsp_z_q;
  assign rsp_n_o     = rsp_n_q;
  assign busy_o      = (state_q != IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter: behavioural ALU plus an ownership /
// preference / response-slot reference model, with directed scenarios first.
module tb_alu_share_arbiter;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req0_lock;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready, req1_lock;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        alu_z, alu_n;
  logic        rsp_valid, rsp_id, rsp_z, rsp_n, rsp_ready, busy;
  logic [31:0] rsp_data;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          owner;      // -1 = no lock, else locking requester
  int          pref;       // requester preferred on a tie
  bit          e_valid, e_id, e_z, e_n;
  logic [31:0] e_data;
  bit          last_r0, last_r1;

  alu_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_a_i(req0_a),
    .req0_b_i(req0_b), .req0_op_i(req0_op), .req0_lock_i(req0_lock),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_a_i(req1_a),
    .req1_b_i(req1_b), .req1_op_i(req1_op), .req1_lock_i(req1_lock),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_out_i(alu_out), .alu_z_i(alu_z), .alu_n_i(alu_n),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
    .rsp_z_o(rsp_z), .rsp_n_o(rsp_n), .rsp_ready_i(rsp_ready), .busy_o(busy)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'b000:  return b + a;
      3'b110:  return 32'd0 - b;
      3'b101:  return b - a;
      3'b111:  return a;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_out = alu_f(alu_a, alu_b, alu_op);
    alu_z   = (alu_out == 32'd0);
    alu_n   = alu_out[31];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; pref = 0;
    e_valid = 0; e_id = 0; e_data = 32'd0; e_z = 0; e_n = 0;
  endtask

  // One cycle: drive at posedge+1, check grants mid-cycle, check response at next posedge+1.
  task automatic step(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [2:0] op0, input bit l0,
                      input bit v1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [2:0] op1, input bit l1, input bit rr);
    bit v[2]; logic [31:0] a[2]; logic [31:0] b[2]; logic [2:0] op[2]; bit l[2];
    int w;
    bit can;
    logic [31:0] r;
    v[0] = v0; a[0] = a0; b[0] = b0; op[0] = op0; l[0] = l0;
    v[1] = v1; a[1] = a1; b[1] = b1; op[1] = op1; l[1] = l1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0; req0_lock = l0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1; req1_lock = l1;
    rsp_ready = rr;
    #4;
    can = !e_valid || rr;
    w = -1;
    if (can) begin
      if (owner >= 0) begin
        if (v[owner]) w = owner;
      end else if (v0 && v1) w = pref;
      else if (v0) w = 0;
      else if (v1) w = 1;
    end
    last_r0 = req0_ready; last_r1 = req1_ready;
    check("req0_ready", {31'd0, req0_ready}, {31'd0, w == 0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, w == 1});
    check("alu_a", alu_a, (w >= 0) ? a[w] : 32'd0);
    check("alu_b", alu_b, (w >= 0) ? b[w] : 32'd0);
    check("alu_op", {29'd0, alu_op}, (w >= 0) ? {29'd0, op[w]} : 32'd0);
    if (w >= 0) begin
      r = alu_f(a[w], b[w], op[w]);
      e_valid = 1; e_id = w[0]; e_data = r; e_z = (r == 32'd0); e_n = r[31];
      if (owner < 0) begin
        if (l[w]) owner = w; else pref = 1 - w;
      end else if (!l[w]) begin
        owner = -1; pref = 1 - w;
      end
    end else if (rr) begin
      e_valid = 0;
    end
    @(posedge clk); #1;
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_valid});
    check("busy", {31'd0, busy}, {31'd0, (owner >= 0) || e_valid});
    if (e_valid) begin
      check("rsp_id", {31'd0, rsp_id}, {31'd0, e_id});
      check("rsp_data", rsp_data, e_data);
      check("rsp_z", {31'd0, rsp_z}, {31'd0, e_z});
      check("rsp_n", {31'd0, rsp_n}, {31'd0, e_n});
    end
  endtask

  task automatic idle_step(input bit rr);
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, rr);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] held;
  bit          first_id;
  int          bound;

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; req0_lock = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; req1_lock = 0;
    rsp_ready = 0;
    model_reset();
    #12;
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // async reset with a pending response and an active lock
    step(1'b1, 32'd1, 32'd2, 3'b000, 1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    #1;
    check("arst_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_data", rsp_data, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'd1, 32'd1, 3'b000, 1'b0, 1'b1, 32'd2, 32'd2, 3'b000, 1'b0, 1'b1);
    check("post_rst_gnt0", {31'd0, last_r0}, 32'd1);

    // req0 only, back-to-back add
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'd5, 32'd7, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1);
      check("add_ready", {31'd0, last_r0}, 32'd1);
      check("add_data", rsp_data, 32'd12);
      check("add_id", {31'd0, rsp_id}, 32'd0);
    end

    // both valid, no lock: grants alternate
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'd3, 32'd3, 3'b101, 1'b0, 1'b1, 32'd0, 32'd1, 3'b110, 1'b0, 1'b1);
      if (i == 0) first_id = rsp_id;
      check("alt_id", {31'd0, rsp_id}, {31'd0, first_id ^ i[0]});
      check("alt_data", rsp_data, rsp_id ? 32'hFFFF_FFFF : 32'd0);
    end

    // req1 locked sequence while req0 stays valid
    step(1'b1, 32'd1, 32'd1, 3'b111, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'd1, 32'd1, 3'b111, 1'b0, 1'b1, 32'd4, i, 3'b000, (i < 2), 1'b1);
      check("lock_r0_blocked", {31'd0, last_r0}, 32'd0);
      check("lock_r1_gnt", {31'd0, last_r1}, 32'd1);
    end
    step(1'b1, 32'd1, 32'd1, 3'b111, 1'b0, 1'b1, 32'd4, 32'd4, 3'b000, 1'b0, 1'b1);
    check("after_lock_r0", {31'd0, last_r0}, 32'd1);

    // backpressure: response holds, nothing granted, then same-cycle refill
    step(1'b1, 32'd8, 32'd1, 3'b000, 1'b0, 1'b1, 32'd2, 32'd3, 3'b000, 1'b0, 1'b1);
    held = rsp_data;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'd8, 32'd1, 3'b000, 1'b0, 1'b1, 32'd2, 32'd3, 3'b000, 1'b0, 1'b0);
      check("bp_r0", {31'd0, last_r0}, 32'd0);
      check("bp_r1", {31'd0, last_r1}, 32'd0);
      check("bp_hold", rsp_data, held);
    end
    step(1'b1, 32'd8, 32'd1, 3'b000, 1'b0, 1'b1, 32'd2, 32'd3, 3'b000, 1'b0, 1'b1);
    check("bp_refill", {31'd0, last_r0 | last_r1}, 32'd1);

    // undefined op-code
    idle_step(1'b1);
    step(1'b1, 32'd9, 32'd4, 3'b011, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1);
    check("undef_data", rsp_data, 32'd0);
    check("undef_z", {31'd0, rsp_z}, 32'd1);
    check("undef_n", {31'd0, rsp_n}, 32'd0);

    // randomized traffic
    bound = 3000;
    for (int i = 0; i < bound; i++) begin
      step($urandom_range(0, 9) < 7, rand_operand(), rand_operand(),
           3'($urandom_range(0, 7)), $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 7, rand_operand(), rand_operand(),
           3'($urandom_range(0, 7)), $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
